vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_if.sv | 12 +
 rtl/vga_timing_gen.sv | 81 ++++++++
 tb/tb_vga_timing_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// Timing bundle carried from the VGA timing generator to downstream pixel stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered
// sync, blanking and frame-start flags that are aligned to the counts they describe.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_VISIBLE = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  vga_if.out   vout,
  output logic frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] HB_START   = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VB_START   = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        hsync_r;
  logic        vsync_r;
  logic        hblnk_r;
  logic        vblnk_r;

  always_comb begin
    h_next = h_cnt + 11'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Flags are decoded from the next count so they land on the same edge as it.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hblnk_r     <= 1'b0;
      vblnk_r     <= 1'b0;
      hsync_r     <= ~SYNC_POL;
      vsync_r     <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hblnk_r     <= (h_next >= HB_START);
      vblnk_r     <= (v_next >= VB_START);
      hsync_r     <= ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_r     <= ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign vout.hcount = h_cnt;
  assign vout.vcount = v_cnt;
  assign vout.hsync  = hsync_r;
  assign vout.vsync  = vsync_r;
  assign vout.hblnk  = hblnk_r;
  assign vout.vblnk  = vblnk_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int   HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int   VV = 10, VF = 2, VS = 3, VB = 4;
  localparam logic POL = 1'b0;
  localparam int   HT = HV + HF + HS + HB;
  localparam int   VT = VV + VF + VS + VB;
  localparam int   FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } t_out;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic frame_start;

  vga_if vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vout       (vif.out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   mh = 0;
  int   mv = 0;
  t_out last_exp;
  t_out exp_q[$];

  function automatic t_out expect_at(int h, int v, bit fs);
    t_out r;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hb = (h >= HV);
    r.vb = (v >= VV);
    r.hs = (h >= HV + HF && h < HV + HF + HS) ? POL : ~POL;
    r.vs = (v >= VV + VF && v < VV + VF + VS) ? POL : ~POL;
    r.fs = fs;
    return r;
  endfunction

  function automatic t_out observe();
    t_out r;
    r.h  = vif.hcount;
    r.v  = vif.vcount;
    r.hs = vif.hsync;
    r.vs = vif.vsync;
    r.hb = vif.hblnk;
    r.vb = vif.vblnk;
    r.fs = frame_start;
    return r;
  endfunction

  function automatic string fmt(t_out o);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b", o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.fs);
  endfunction

  // Drives one clock, pushing the model's view of the following output.
  task automatic drive(bit r, bit e);
    t_out x;
    rst = r;
    en  = e;
    if (r) begin
      mh = 0;
      mv = 0;
      x = expect_at(0, 0, 1'b0);
    end else if (e) begin
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1 == VT) ? 0 : mv + 1;
      end
      x = expect_at(mh, mv, (mh == 0) && (mv == 0));
    end else begin
      x = last_exp;
      x.fs = 1'b0;
    end
    last_exp = x;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int th, int tv);
    t_out got, want;
    int n = 0;
    while (!(mh == th && mv == tv) && n < FRAME + 2) begin
      drive(1'b0, 1'b1);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL advance: got %s, want %s", fmt(got), fmt(want));
      end
      n++;
    end
    checks++;
    if (!(mh == th && mv == tv)) begin
      errors++;
      $display("FAIL advance_timeout: got h=%0d v=%0d, want h=%0d v=%0d", mh, mv, th, tv);
    end
  endtask

  task automatic test_reset();
    t_out got, want;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0]);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset: got %s, want %s", fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_first_count();
    t_out got, want;
    drive(1'b0, 1'b1);
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL first_count: got %s, want %s", fmt(got), fmt(want));
    end
    checks++;
    if (got.h !== 11'd1 || got.v !== 11'd0 || got.fs !== 1'b0) begin
      errors++;
      $display("FAIL first_count_pos: got %s, want h=1 v=0 fs=0", fmt(got));
    end
  endtask

  task automatic test_frame_period();
    t_out got, want;
    int pulses = 0;
    int first_at = -1;
    int second_at = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive(1'b0, 1'b1);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_period_cycle: got %s, want %s", fmt(got), fmt(want));
      end
      if (got.fs === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_pulses: got %0d, want 2", pulses);
    end
    checks++;
    if (second_at - first_at != FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d, want %0d", second_at - first_at, FRAME);
    end
  endtask

  task automatic test_line_sweep();
    t_out got, want;
    int  rise_h = -1;
    int  sync_start = -1;
    int  sync_len = 0;
    bit  prev_hb = 1'b0;
    bit  fell_at_zero = 1'b0;
    run_to(0, 2);
    for (int i = 0; i < HT; i++) begin
      drive(1'b0, 1'b1);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL line_sweep: got %s, want %s", fmt(got), fmt(want));
      end
      if (got.hb === 1'b1 && !prev_hb && rise_h < 0) rise_h = int'(got.h);
      if (got.hb === 1'b0 && prev_hb && got.h === 11'd0) fell_at_zero = 1'b1;
      if (got.hs === POL) begin
        if (sync_start < 0) sync_start = int'(got.h);
        sync_len++;
      end
      prev_hb = got.hb;
    end
    checks++;
    if (rise_h != HV) begin
      errors++;
      $display("FAIL hblnk_rise: got %0d, want %0d", rise_h, HV);
    end
    checks++;
    if (!fell_at_zero) begin
      errors++;
      $display("FAIL hblnk_fall: got no fall at hcount 0, want fall at 0");
    end
    checks++;
    if (sync_start != HV + HF || sync_len != HS) begin
      errors++;
      $display("FAIL hsync_window: got start=%0d len=%0d, want start=%0d len=%0d",
               sync_start, sync_len, HV + HF, HS);
    end
  endtask

  task automatic test_frame_sweep();
    t_out got, want;
    t_out prev;
    int vb_cycles = 0;
    int vs_cycles = 0;
    int vs_first = -1;
    int bad_edges = 0;
    run_to(0, 0);
    prev = observe();
    for (int i = 0; i < FRAME; i++) begin
      drive(1'b0, 1'b1);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_sweep: got %s, want %s", fmt(got), fmt(want));
      end
      if (got.vb === 1'b1) vb_cycles++;
      if (got.vs === POL) begin
        vs_cycles++;
        if (vs_first < 0) vs_first = int'(got.v);
      end
      if (got.vs !== prev.vs && got.h !== 11'd0) bad_edges++;
      prev = got;
    end
    checks++;
    if (vb_cycles != (VT - VV) * HT) begin
      errors++;
      $display("FAIL vblnk_span: got %0d, want %0d", vb_cycles, (VT - VV) * HT);
    end
    checks++;
    if (vs_cycles != VS * HT || vs_first != VV + VF) begin
      errors++;
      $display("FAIL vsync_window: got cycles=%0d first=%0d, want cycles=%0d first=%0d",
               vs_cycles, vs_first, VS * HT, VV + VF);
    end
    checks++;
    if (bad_edges != 0) begin
      errors++;
      $display("FAIL vsync_edge: got %0d edges off hcount 0, want 0", bad_edges);
    end
  endtask

  task automatic test_wrap_corner();
    t_out got, want;
    run_to(HT - 1, VT - 1);
    drive(1'b0, 1'b1);
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL wrap_corner: got %s, want %s", fmt(got), fmt(want));
    end
    checks++;
    if (got.h !== 11'd0 || got.v !== 11'd0 || got.fs !== 1'b1 || got.vb !== 1'b0 || got.hb !== 1'b0) begin
      errors++;
      $display("FAIL wrap_corner_pos: got %s, want h=0 v=0 fs=1 hb=0 vb=0", fmt(got));
    end
  endtask

  task automatic test_enable_hold();
    t_out got, want, snap;
    run_to(10, 5);
    snap = observe();
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || got.h !== snap.h || got.v !== snap.v || got.fs !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold: got %s, want %s", fmt(got), fmt(want));
      end
    end
    drive(1'b0, 1'b1);
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || got.h !== 11'd11 || got.v !== 11'd5) begin
      errors++;
      $display("FAIL enable_resume: got %s, want h=11 v=5", fmt(got));
    end
  endtask

  task automatic test_reset_mid();
    t_out got, want;
    int n = 0;
    run_to(12, 6);
    drive(1'b1, 1'b1);
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || got.h !== 11'd0 || got.v !== 11'd0 || got.hb !== 1'b0 ||
        got.vb !== 1'b0 || got.hs !== ~POL || got.vs !== ~POL || got.fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %s, want %s", fmt(got), fmt(want));
    end
    drive(1'b0, 1'b1);
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want || got.h !== 11'd1 || got.v !== 11'd0 || got.fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resume: got %s, want h=1 v=0 fs=0", fmt(got));
    end
    do begin
      drive(1'b0, 1'b1);
      got = observe();
      want = exp_q.pop_front();
      n++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_run: got %s, want %s", fmt(got), fmt(want));
      end
    end while (got.fs !== 1'b1 && n < FRAME + 2);
    checks++;
    if (n != FRAME - 1 || got.h !== 11'd0 || got.v !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_first_fs: got after %0d clocks at h=%0d v=%0d, want after %0d at h=0 v=0",
               n, got.h, got.v, FRAME - 1);
    end
  endtask

  initial begin
    last_exp = expect_at(0, 0, 1'b0);
    test_reset();
    test_first_count();
    test_frame_period();
    test_line_sweep();
    test_frame_sweep();
    test_wrap_corner();
    test_enable_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
